mem_arbiter: RTL

- Shares the single main_memory port between the instruction-cache refill path (read only) and the data-cache path (line refill or line write-back).
- Sequences main_memory's multi-cycle protocol on each requester's behalf:
  - holds mem_read until ready_to_read, then captures the 4-word line;
  - issues 4 word-write beats, then waits for finished_writing.
- Sits between the cache controllers and main_memory. Arbitration is round-robin on conflict.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter, the two cache controllers and main_memory.
// master = arbiter side, slave = requesters plus memory (environment side).
interface mem_arbiter_if #(
  parameter int add_width  = 10,
  parameter int data_width = 32
);
  // Requests are levels held until the matching one-cycle done pulse;
  // memory handshakes are sampled only in the state that waits on them.
  logic                    i_req;
  logic [add_width-1:0]    i_addr;
  logic [4*data_width-1:0] i_rdata;
  logic                    i_done;
  logic                    d_req;
  logic                    d_we;
  logic [add_width-1:0]    d_addr;
  logic [4*data_width-1:0] d_wdata;
  logic [4*data_width-1:0] d_rdata;
  logic                    d_done;
  logic                    err;
  logic                    busy;
  logic [add_width-1:0]    mem_add;
  logic [data_width-1:0]   mem_write_data;
  logic                    mem_read;
  logic                    mem_write;
  logic [4*data_width-1:0] mem_read_data;
  logic                    mem_ready_to_read;
  logic                    mem_finished_writing;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_read_data, mem_ready_to_read, mem_finished_writing,
    output i_rdata, i_done, d_rdata, d_done, err, busy,
           mem_add, mem_write_data, mem_read, mem_write
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_read_data, mem_ready_to_read, mem_finished_writing,
    input  i_rdata, i_done, d_rdata, d_done, err, busy,
           mem_add, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing main_memory between I-cache refills and
// D-cache refills/write-backs, sequencing the memory's read and 4-beat write protocol.
module mem_arbiter #(
  parameter int add_width  = 10,
  parameter int data_width = 32,
  parameter int timeout    = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {IDLE, RD, WR, WR_WAIT, DONE} state_t;

  localparam int CW = $clog2(timeout + 1);

  state_t                  state, state_next;
  logic                    gnt_d;     // granted side: 1 = D, 0 = I
  logic                    rr_last;   // last granted side, same encoding
  logic                    err_flag;
  logic [1:0]              beat;
  logic [CW-1:0]           wait_cnt;
  logic [add_width-1:0]    line_addr;
  logic [4*data_width-1:0] wline;
  logic [4*data_width-1:0] i_line, d_line;
  logic                    req_any, pick_d, timed_out;
  logic                    unused_low_bits;

  assign req_any   = bus.i_req | bus.d_req;
  // On conflict the side that was not served last wins.
  assign pick_d    = bus.d_req & (~bus.i_req | ~rr_last);
  assign timed_out = (wait_cnt == CW'(timeout - 1));
  assign unused_low_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_any) state_next = (pick_d & bus.d_we) ? WR : RD;
      RD:      if (bus.mem_ready_to_read || timed_out) state_next = DONE;
      WR:      if (beat == 2'd3) state_next = WR_WAIT;
      WR_WAIT: if (bus.mem_finished_writing || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_d     <= 1'b0;
      rr_last   <= 1'b0;
      err_flag  <= 1'b0;
      beat      <= 2'd0;
      wait_cnt  <= '0;
      line_addr <= '0;
      wline     <= '0;
      i_line    <= '0;
      d_line    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt_d     <= pick_d;
            rr_last   <= pick_d;
            err_flag  <= 1'b0;
            line_addr <= pick_d ? {bus.d_addr[add_width-1:2], 2'b00}
                                : {bus.i_addr[add_width-1:2], 2'b00};
            if (pick_d && bus.d_we) wline <= bus.d_wdata;
          end
        end
        RD: begin
          if (bus.mem_ready_to_read) begin
            if (gnt_d) d_line <= bus.mem_read_data;
            else       i_line <= bus.mem_read_data;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (timed_out) err_flag <= 1'b1;
          end
        end
        WR: beat <= beat + 2'd1;
        WR_WAIT: begin
          if (!bus.mem_finished_writing) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (timed_out) err_flag <= 1'b1;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          beat     <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and completion pulses decode straight from the state,
  // so a reset removes them in the very next cycle.
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_add        = '0;
    bus.mem_write_data = '0;
    bus.i_done         = 1'b0;
    bus.d_done         = 1'b0;
    bus.err            = 1'b0;
    case (state)
      RD: begin
        bus.mem_read = 1'b1;
        bus.mem_add  = line_addr;
      end
      WR: begin
        bus.mem_write      = 1'b1;
        bus.mem_add        = {line_addr[add_width-1:2], beat};
        bus.mem_write_data = wline[int'(beat)*data_width +: data_width];
      end
      DONE: begin
        bus.i_done = ~gnt_d;
        bus.d_done = gnt_d;
        bus.err    = err_flag;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.i_rdata = i_line;
  assign bus.d_rdata = d_line;
  assign fsm_state   = state;

endmodule
